// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin scheduler that shares one UART sif port among N_CLIENTS byte producers.
// Define UART_TX_ARB_LOCK_EN to add the lock port that keeps a locked client's packet contiguous.
module uart_tx_arb #(
    parameter int N_CLIENTS = 4,
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = 8'h08,
    parameter logic [ADDR_W-1:0] TX_ADDR = 8'h00,
    parameter int BUSY_BIT = 0,
    parameter int POLL_MAX = 1023
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [N_CLIENTS-1:0]         req,
    input  logic [8*N_CLIENTS-1:0]       data,
    output logic [N_CLIENTS-1:0]         ack,
    output logic [N_CLIENTS-1:0]         err,
    output logic [$clog2(N_CLIENTS)-1:0] grant_id,
    output logic                         busy,
    output logic [ADDR_W-1:0]            sif_addr,
    output logic                         sif_re,
    output logic                         sif_we,
    output logic [31:0]                  sif_wd,
    input  logic [31:0]                  sif_rd
`ifdef UART_TX_ARB_LOCK_EN
    ,
    input  logic [N_CLIENTS-1:0]         lock
`endif
);
    localparam int GW = $clog2(N_CLIENTS);
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [1:0] IDLE = 2'd0, POLL = 2'd1, CHECK = 2'd2, WRITE = 2'd3;

    logic [1:0]           state;
    logic [GW-1:0]        last_grant;
    logic [GW-1:0]        pick;
    logic [PW-1:0]        poll_cnt;
    logic [7:0]           byte_q;
    logic                 found;
    logic [GW:0]          s;
    logic [N_CLIENTS-1:0] one_hot;
    logic                 unused_rd;
`ifdef UART_TX_ARB_LOCK_EN
    logic                 hold;
`endif

    assign unused_rd = ^sif_rd;
    assign one_hot = {{(N_CLIENTS-1){1'b0}}, 1'b1} << grant_id;

    // first requester after last_grant, wrapping mod N_CLIENTS
    always_comb begin
        pick = last_grant;
        found = 1'b0;
        s = '0;
        for (int k = 1; k <= N_CLIENTS; k++) begin
            s = {1'b0, last_grant} + k[GW:0];
            if (s >= (GW+1)'(N_CLIENTS)) s = s - (GW+1)'(N_CLIENTS);
            if (!found && req[s[GW-1:0]]) begin
                pick = s[GW-1:0];
                found = 1'b1;
            end
        end
`ifdef UART_TX_ARB_LOCK_EN
        if (hold && req[grant_id]) pick = grant_id;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            ack <= '0;
            err <= '0;
            sif_re <= 1'b0;
            sif_we <= 1'b0;
            sif_addr <= '0;
            sif_wd <= '0;
            busy <= 1'b0;
            grant_id <= '0;
            poll_cnt <= '0;
            byte_q <= '0;
            last_grant <= GW'(N_CLIENTS - 1);
`ifdef UART_TX_ARB_LOCK_EN
            hold <= 1'b0;
`endif
        end else begin
            ack <= '0;
            err <= '0;
            sif_re <= 1'b0;
            sif_we <= 1'b0;
            case (state)
                IDLE: if (|req) begin
                    grant_id <= pick;
                    byte_q <= data[8*pick +: 8];
                    poll_cnt <= '0;
                    sif_re <= 1'b1;
                    sif_addr <= STATUS_ADDR;
                    busy <= 1'b1;
                    state <= POLL;
`ifdef UART_TX_ARB_LOCK_EN
                    hold <= 1'b0;
`endif
                end
                POLL: state <= CHECK;
                CHECK: if (!sif_rd[BUSY_BIT]) begin
                    sif_we <= 1'b1;
                    sif_addr <= TX_ADDR;
                    sif_wd <= {24'h0, byte_q};
                    ack <= one_hot;
                    state <= WRITE;
                end else if (poll_cnt != PW'(POLL_MAX)) begin
                    poll_cnt <= poll_cnt + 1'b1;
                    sif_re <= 1'b1;
                    sif_addr <= STATUS_ADDR;
                    state <= POLL;
                end else begin
                    err <= one_hot;
                    last_grant <= grant_id;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy <= 1'b0;
                    state <= IDLE;
`ifdef UART_TX_ARB_LOCK_EN
                    hold <= lock[grant_id];
                    if (!lock[grant_id]) last_grant <= grant_id;
`else
                    last_grant <= grant_id;
`endif
                end
            endcase
        end
    end
endmodule
